// File: rtl/bit_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : bit_debounce
//  Purpose  : Single-bit debouncer with one-cycle rise/fall pulses. The input
//             must differ from the current output for STABLE_CYCLES
//             consecutive samples before the output follows it.
//  Options  : define BIT_DEBOUNCE_EDGE_CNT_EN to add the edge_cnt output,
//             a wrapping count of qualified transitions.
//  Revision : 1.0 - initial release
// ============================================================================
module bit_debounce #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic        RST_VAL       = 1'b0,
    parameter int unsigned EDGE_CNT_W    = 8
) (
    input  logic                  aclk,
    input  logic                  srst,
    input  logic                  d,
    output logic                  q,
    output logic                  rise,
    output logic                  fall,
    output logic                  busy
`ifdef BIT_DEBOUNCE_EDGE_CNT_EN
    ,
    output logic [EDGE_CNT_W-1:0] edge_cnt
`endif
);

    localparam int unsigned      CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    // With a one-sample window the output follows straight from IDLE.
    localparam logic             c_SINGLE   = (STABLE_CYCLES == 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_CHECK = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             r_rise;
    logic             r_fall;
    logic             r_busy;

    logic             w_diff;
    logic             w_update;

    // Qualification decision: does this edge commit a new output level?
    always_comb begin
        w_diff   = (d != r_q);
        w_update = 1'b0;
        if (w_diff) begin
            if ((r_state == c_IDLE) && c_SINGLE) begin
                w_update = 1'b1;
            end else if ((r_state == c_CHECK) && (r_cnt == c_CNT_LAST)) begin
                w_update = 1'b1;
            end
        end
    end

    // Debounce state machine, sample counter and registered outputs.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_q     <= RST_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-armed below.
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_update) begin
                r_q     <= d;
                r_rise  <= d;
                r_fall  <= ~d;
                r_cnt   <= '0;
                r_state <= c_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_diff) begin
                            r_cnt   <= c_CNT_ONE;
                            r_state <= c_CHECK;
                            r_busy  <= 1'b1;
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    c_CHECK: begin
                        if (!w_diff) begin
                            // Input fell back before qualifying: glitch.
                            r_cnt   <= '0;
                            r_state <= c_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BIT_DEBOUNCE_EDGE_CNT_EN
    logic [EDGE_CNT_W-1:0] r_edge_cnt;

    // Count every committed transition; wraps naturally at all-ones.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_edge_cnt <= '0;
        end else if (w_update) begin
            r_edge_cnt <= r_edge_cnt + {{(EDGE_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign edge_cnt = r_edge_cnt;
`endif

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bit_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_debounce
//  Purpose  : Directed self-checking bench for bit_debounce. Two instances
//             share clock and reset: one with STABLE_CYCLES=4, one with
//             STABLE_CYCLES=1. Expected {q,rise,fall,busy} per edge are
//             hand-computed constants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bit_debounce;

    logic clk  = 1'b0;
    logic srst = 1'b1;
    logic d4   = 1'b0;
    logic d1   = 1'b0;

    logic q4, rise4, fall4, busy4;
    logic q1, rise1, fall1, busy1;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Expected transition counts (2-bit, wrap at 4).
    logic [1:0] ec4 = 2'd0;
    logic [1:0] ec1 = 2'd0;

`ifdef BIT_DEBOUNCE_EDGE_CNT_EN
    logic [1:0] edge_cnt4;
    logic [1:0] edge_cnt1;
`endif

    always #5 clk = ~clk;

    bit_debounce #(
        .STABLE_CYCLES (4),
        .RST_VAL       (1'b0),
        .EDGE_CNT_W    (2)
    ) u_dut4 (
        .aclk     (clk),
        .srst     (srst),
        .d        (d4),
        .q        (q4),
        .rise     (rise4),
        .fall     (fall4),
        .busy     (busy4)
`ifdef BIT_DEBOUNCE_EDGE_CNT_EN
        ,
        .edge_cnt (edge_cnt4)
`endif
    );

    bit_debounce #(
        .STABLE_CYCLES (1),
        .RST_VAL       (1'b0),
        .EDGE_CNT_W    (2)
    ) u_dut1 (
        .aclk     (clk),
        .srst     (srst),
        .d        (d1),
        .q        (q1),
        .rise     (rise1),
        .fall     (fall1),
        .busy     (busy1)
`ifdef BIT_DEBOUNCE_EDGE_CNT_EN
        ,
        .edge_cnt (edge_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock edge, then check both instances 1 time unit later.
    // Expected vectors are {q, rise, fall, busy}.
    task automatic step(input string tag, input logic [3:0] e4, input logic [3:0] e1);
        @(posedge clk);
        #1;
        if (srst) begin
            ec4 = 2'd0;
            ec1 = 2'd0;
        end else begin
            if (e4[2] | e4[1]) ec4 = ec4 + 2'd1;
            if (e1[2] | e1[1]) ec1 = ec1 + 2'd1;
        end
        chk({tag, "_s4"}, {q4, rise4, fall4, busy4}, e4);
        chk({tag, "_s1"}, {q1, rise1, fall1, busy1}, e1);
`ifdef BIT_DEBOUNCE_EDGE_CNT_EN
        chk({tag, "_ec4"}, {2'b00, edge_cnt4}, {2'b00, ec4});
        chk({tag, "_ec1"}, {2'b00, edge_cnt1}, {2'b00, ec1});
`endif
    endtask

    initial begin
        // Reset held 3 edges while inputs toggle.
        srst = 1'b1;
        d4 = 1'b1; d1 = 1'b1; step("rst0", 4'b0000, 4'b0000);
        d4 = 1'b0; d1 = 1'b0; step("rst1", 4'b0000, 4'b0000);
        d4 = 1'b1; d1 = 1'b1; step("rst2", 4'b0000, 4'b0000);

        // Release with inputs low: everything stays idle.
        srst = 1'b0; d4 = 1'b0; d1 = 1'b0;
        step("idle0", 4'b0000, 4'b0000);
        step("idle1", 4'b0000, 4'b0000);

        // Clean rise: busy for 3 cycles, q and rise on the 4th sample.
        d4 = 1'b1;
        step("rise_k0", 4'b0001, 4'b0000);
        step("rise_k1", 4'b0001, 4'b0000);
        step("rise_k2", 4'b0001, 4'b0000);
        step("rise_k3", 4'b1100, 4'b0000);
        step("rise_k4", 4'b1000, 4'b0000);

        // Three-sample low glitch is rejected.
        d4 = 1'b0;
        step("glt_0", 4'b1001, 4'b0000);
        step("glt_1", 4'b1001, 4'b0000);
        step("glt_2", 4'b1001, 4'b0000);
        d4 = 1'b1;
        step("glt_3", 4'b1000, 4'b0000);
        step("glt_4", 4'b1000, 4'b0000);

        // Four-sample low qualifies: single fall pulse.
        d4 = 1'b0;
        step("fall_0", 4'b1001, 4'b0000);
        step("fall_1", 4'b1001, 4'b0000);
        step("fall_2", 4'b1001, 4'b0000);
        step("fall_3", 4'b0010, 4'b0000);
        step("fall_4", 4'b0000, 4'b0000);

        // STABLE_CYCLES=1 instance follows d every edge.
        d1 = 1'b1; step("tog_0", 4'b0000, 4'b1100);
        d1 = 1'b0; step("tog_1", 4'b0000, 4'b0010);
        d1 = 1'b1; step("tog_2", 4'b0000, 4'b1100);
        d1 = 1'b0; step("tog_3", 4'b0000, 4'b0010);
        d1 = 1'b1; step("tog_4", 4'b0000, 4'b1100);
        d1 = 1'b0; step("tog_5", 4'b0000, 4'b0010);

        // Back-to-back: new qualification starts on the edge after an update.
        d4 = 1'b1;
        step("b2b_0", 4'b0001, 4'b0000);
        step("b2b_1", 4'b0001, 4'b0000);
        step("b2b_2", 4'b0001, 4'b0000);
        step("b2b_3", 4'b1100, 4'b0000);
        d4 = 1'b0;
        step("b2b_4", 4'b1001, 4'b0000);
        step("b2b_5", 4'b1001, 4'b0000);
        step("b2b_6", 4'b1001, 4'b0000);
        step("b2b_7", 4'b0010, 4'b0000);
        step("b2b_8", 4'b0000, 4'b0000);

        // Bring q high again, then reset mid-qualification.
        d4 = 1'b1;
        step("mid_0", 4'b0001, 4'b0000);
        step("mid_1", 4'b0001, 4'b0000);
        step("mid_2", 4'b0001, 4'b0000);
        step("mid_3", 4'b1100, 4'b0000);
        d4 = 1'b0;
        step("mid_4", 4'b1001, 4'b0000);
        step("mid_5", 4'b1001, 4'b0000);
        srst = 1'b1;
        step("mid_rst0", 4'b0000, 4'b0000);
        step("mid_rst1", 4'b0000, 4'b0000);
        srst = 1'b0;
        step("mid_post0", 4'b0000, 4'b0000);
        step("mid_post1", 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
